// File: rtl/imm_signext_pkg.sv
// Shared RV32I decode definitions: major-opcode constants (instr[6:2]) and the
// immediate-format classification used by the immediate generator and control.
package riscv_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  // Map a major opcode to its immediate format; anything unlisted carries none.
  function automatic imm_type_e opToImmType(input logic [4:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: return IMM_I;
      OP_STORE:                 return IMM_S;
      OP_BRANCH:                return IMM_B;
      OP_JAL:                   return IMM_J;
      OP_LUI, OP_AUIPC:         return IMM_U;
      default:                  return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/imm_signext_if.sv
// Decode-stage immediate bus: instruction fields in, registered immediate out.
interface imm_signext_if #(
  parameter int XLEN = 32
);
  logic            en;
  logic [24:0]     DataIn;    // instr[31:7]
  logic [4:0]      Op;        // instr[6:2]
  logic [XLEN-1:0] SignImm;
  logic            ImmValid;

  // Producer of instruction fields / consumer of the immediate.
  modport master (output en, DataIn, Op, input SignImm, ImmValid);
  // The immediate generator itself.
  modport slave  (input en, DataIn, Op, output SignImm, ImmValid);
endinterface

// File: rtl/imm_signext_decode.sv
// Combinational RV32I immediate decoder. Pure bit selection: the sign bit is
// always DataIn[24] (instr[31]). Reusable by the control unit.
module imm_decode
  import riscv_pkg::*;
(
  input  logic [24:0] DataIn,
  input  logic [4:0]  Op,
  output logic [31:0] imm,
  output imm_type_e   immType,
  output logic        valid
);

  logic signBit;

  assign signBit = DataIn[24];
  assign immType = opToImmType(Op);
  assign valid   = (immType != IMM_NONE);

  // Assemble the immediate for the decoded format; unknown formats give zero.
  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path driven,
    // so no latch is inferred and unsupported opcodes yield a clean 0.
    imm = '0;
    case (immType)
      IMM_I: imm = {{20{signBit}}, DataIn[24:13]};
      IMM_S: imm = {{20{signBit}}, DataIn[24:18], DataIn[4:0]};
      IMM_B: imm = {{19{signBit}}, DataIn[24], DataIn[0], DataIn[23:18],
                    DataIn[4:1], 1'b0};
      IMM_J: imm = {{11{signBit}}, DataIn[24], DataIn[12:5], DataIn[13],
                    DataIn[23:14], 1'b0};
      IMM_U: imm = {DataIn[24:5], 12'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_signext.sv
// Registered immediate generator for the decode stage: one cycle of latency
// between the instruction fields and SignImm/ImmValid, with a stage enable.
// Only XLEN = 32 is supported.
module imm_signext #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  imm_signext_if.slave bus
);
  import riscv_pkg::*;

  logic [XLEN-1:0] immNext;
  imm_type_e       immType;
  logic            validNext;

  imm_decode uDecode (
    .DataIn (bus.DataIn),
    .Op     (bus.Op),
    .imm    (immNext),
    .immType(immType),
    .valid  (validNext)
  );

  // Output registers: cleared by async reset, loaded when the stage is enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.SignImm  <= '0;
      bus.ImmValid <= 1'b0;
    end else if (bus.en) begin
      // NOTE: non-blocking assignments so every register samples the values
      // present at the edge, independent of statement order.
      bus.SignImm  <= immNext;
      bus.ImmValid <= validNext;
    end
  end

endmodule

// File: tb/tb_imm_signext.sv
// Scoreboard bench for imm_signext: each applied vector pushes its expected
// output (from a reference model written over the full instruction word),
// popped and compared one edge later.
module tb_imm_signext;

  logic clk = 1'b0;
  logic reset = 1'b0;

  imm_signext_if #(.XLEN(32)) bus ();

  imm_signext #(.XLEN(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm;
    logic        valid;
  } exp_t;

  exp_t sbQ[$];
  exp_t heldExp;

  int vecCount  = 0;
  int missCount = 0;

  // Single comparison point for the whole bench.
  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Reference model expressed on the rebuilt 32-bit instruction word.
  function automatic exp_t refModel(input logic [24:0] din, input logic [4:0] op);
    logic [31:0] ins;
    exp_t r;
    ins = {din, op, 2'b11};
    r.valid = 1'b1;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: r.imm = {{20{ins[31]}}, ins[31:20]};
      7'b0100011: r.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      7'b1100011: r.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      7'b1101111: r.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      7'b0110111, 7'b0010111: r.imm = {ins[31:12], 12'h000};
      default: begin
        r.imm   = 32'h0;
        r.valid = 1'b0;
      end
    endcase
    return r;
  endfunction

  // Drive one vector for one edge, queue its expectation, then compare.
  task automatic applyVec(input string tag, input logic en, input logic [24:0] din,
                          input logic [4:0] op);
    exp_t e;
    @(negedge clk);
    bus.en     = en;
    bus.DataIn = din;
    bus.Op     = op;
    if (en) heldExp = refModel(din, op);
    sbQ.push_back(heldExp);
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      checkVal({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = sbQ.pop_front();
      checkVal({tag, "_imm"}, bus.SignImm, e.imm);
      checkVal({tag, "_valid"}, {31'b0, bus.ImmValid}, {31'b0, e.valid});
      checkVal({tag, "_noX"}, {31'b0, $isunknown({bus.SignImm, bus.ImmValid})}, 32'h0);
    end
  endtask

  // Direct check against a hand-computed constant (independent of the model).
  task automatic checkConst(input string tag, input logic [31:0] imm, input logic valid);
    checkVal({tag, "_kimm"}, bus.SignImm, imm);
    checkVal({tag, "_kvalid"}, {31'b0, bus.ImmValid}, {31'b0, valid});
  endtask

  localparam logic [24:0] D_I = 25'b000011011011_0000000000000;
  localparam logic [24:0] D_S = 25'b1111001_0000000000000_11011;
  localparam logic [24:0] D_B = 25'b0_000101_0000000000000_1111_1;
  localparam logic [24:0] D_J = 25'b1_1100001010_0_10101111_00000;
  localparam logic [24:0] D_U = 25'h1ABCDE0;

  initial begin
    logic [4:0] opList[12];
    opList = '{5'b00000, 5'b00100, 5'b11001, 5'b01000, 5'b11000, 5'b11011,
               5'b01101, 5'b00101, 5'b01100, 5'b11100, 5'b00011, 5'b11111};
    heldExp.imm   = 32'h0;
    heldExp.valid = 1'b0;
    bus.en     = 1'b1;
    bus.DataIn = 25'($urandom);
    bus.Op     = 5'b01101;

    // Asynchronous reset with random inputs, held across edges.
    #2 reset = 1'b1;
    #1;
    checkConst("rst_async", 32'h0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      bus.DataIn = 25'($urandom);
      bus.Op     = 5'b01101;
      @(posedge clk);
      #1;
      checkConst("rst_hold", 32'h0, 1'b0);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkConst("rst_release", 32'h0, 1'b0);

    // Directed formats.
    applyVec("i_load", 1'b1, D_I, 5'b00000);  checkConst("i_load", 32'h000000DB, 1'b1);
    applyVec("i_opimm", 1'b1, D_I, 5'b00100); checkConst("i_opimm", 32'h000000DB, 1'b1);
    applyVec("i_jalr", 1'b1, D_I, 5'b11001);  checkConst("i_jalr", 32'h000000DB, 1'b1);
    applyVec("s", 1'b1, D_S, 5'b01000);       checkConst("s", 32'hFFFFFF3B, 1'b1);
    applyVec("b", 1'b1, D_B, 5'b11000);       checkConst("b", 32'h000008BE, 1'b1);
    applyVec("j", 1'b1, D_J, 5'b11011);       checkConst("j", 32'hFFFAF614, 1'b1);
    applyVec("u_lui", 1'b1, D_U, 5'b01101);   checkConst("u_lui", 32'hD5E6F000, 1'b1);
    applyVec("u_auipc", 1'b1, D_U, 5'b00101); checkConst("u_auipc", 32'hD5E6F000, 1'b1);
    applyVec("inv", 1'b1, D_J, 5'b01100);     checkConst("inv", 32'h0, 1'b0);

    // Enable/hold.
    applyVec("hold_load", 1'b1, D_S, 5'b01000);
    for (int i = 0; i < 3; i++) begin
      applyVec("hold", 1'b0, D_B, 5'b11000);
      checkConst("hold", 32'hFFFFFF3B, 1'b1);
    end
    applyVec("hold_resume", 1'b1, D_B, 5'b11000);
    checkConst("hold_resume", 32'h000008BE, 1'b1);

    // Sign-bit extremes.
    applyVec("i_allones", 1'b1, 25'h1FFFFFF, 5'b00000);
    checkConst("i_allones", 32'hFFFFFFFF, 1'b1);
    applyVec("j_allones", 1'b1, 25'h1FFFFFF, 5'b11011);
    checkConst("j_allones", 32'hFFFFFFFE, 1'b1);
    applyVec("b_zero", 1'b1, 25'h0, 5'b11000);
    checkConst("b_zero", 32'h0, 1'b1);

    // Mid-stream asynchronous reset, then resume.
    applyVec("pre_rst", 1'b1, D_J, 5'b11011);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checkConst("rst_mid", 32'h0, 1'b0);
    #1 reset = 1'b0;
    heldExp.imm   = 32'h0;
    heldExp.valid = 1'b0;
    applyVec("post_rst", 1'b1, D_U, 5'b00101);

    // Random vectors across all opcode classes with random enable.
    for (int i = 0; i < 300; i++) begin
      applyVec("rand", 1'($urandom_range(0, 3) != 0), 25'($urandom),
               opList[$urandom_range(0, 11)]);
    end

    checkVal("sb_drained", sbQ.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  // Watchdog: the run must end on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imm_signext.md
Name: imm_signext

Overview:
- Immediate generator for the RV32I decode stage.
- Takes instruction bits [31:7] and opcode bits [6:2], and produces a sign-extended 32-bit immediate.
- The immediate is formatted per instruction type (I/S/B/U/J) and registered for one cycle before use by the execute stage.
- Also flags whether the opcode carries an immediate.

Parameters:
- XLEN, 32, output immediate width; only 32 supported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  stage enable; when 0, output registers hold their value
- DataIn  input  25  instruction bits [31:7]; DataIn[k] = instr[k+7]
- Op  input  5  opcode bits [6:2] (instr[1:0]=2'b11 implied)
- SignImm  output  32  registered sign-extended immediate
- ImmValid  output  1  registered; 1 when Op is a supported immediate-bearing opcode

Behaviour:
- Reset (async, active-high): SignImm=32'h0, ImmValid=0 immediately, held while reset=1.
- Latency: 1 cycle. On each rising clk with en=1, both outputs load the combinational decode of the DataIn/Op values present at that edge.
- With en=0 both outputs hold their value.
- Decode by Op (the sign bit is always DataIn[24] = instr[31]):
  - I-type, Op ∈ {00000 load, 00100 op-imm, 11001 jalr}: imm = sext(DataIn[24:13]), i.e. 12 bits.
  - S-type, Op=01000: imm = sext({DataIn[24:18], DataIn[4:0]}).
  - B-type, Op=11000: imm = sext({DataIn[24], DataIn[0], DataIn[23:18], DataIn[4:1], 1'b0}), 13 bits, LSB 0.
  - J-type, Op=11011: imm = sext({DataIn[24], DataIn[12:5], DataIn[13], DataIn[23:14], 1'b0}), 21 bits, LSB 0.
  - U-type, Op ∈ {01101 lui, 00101 auipc}: imm = {DataIn[24:5], 12'b0}; no extension needed.
  - Any other Op (e.g. 01100 R-type, 11100 system, reserved): imm = 32'h0, ImmValid=0. The outputs are never X.
- ImmValid=1 for every supported Op listed above.
- Purely bit-select/concatenation; no arithmetic. Results are exact for all 2^25 DataIn values.
- Reset deasserted mid-stream: first load occurs on the first rising edge after deassertion.
- Simultaneous reset and clk edge: reset wins.

Decomposition:
- Shared package riscv_pkg holds:
  - 5-bit opcode constants: OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC.
  - enum imm_type_e {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}.
- One combinational sub-module, imm_decode (DataIn, Op -> imm[31:0], imm_type, valid), feeds the registers in imm_signext. The same sub-module is reusable by the control unit.

Test Plan:
- Reset: assert reset with random inputs -> SignImm=0, ImmValid=0 asynchronously; both stay 0 until the first edge after release.
- I-type: DataIn=25'b000011011011_0000000000000, Op=00000, one edge -> SignImm=32'h000000DB, ImmValid=1. The same DataIn with Op=00100 and 11001 gives the same result.
- S-type: DataIn=25'b1111001_0000000000000_11011, Op=01000 -> SignImm=32'hFFFFFF3B. B-type: DataIn=25'b0_000101_0000000000000_1111_1, Op=11000 -> SignImm=32'h000008BE.
- J-type: DataIn=25'b1_1100001010_0_10101111_00000, Op=11011 -> SignImm=32'hFFFAF614. U-type: DataIn=25'h1ABCDE0 (DataIn[24:5]=20'hD5E6F), Op=01101 -> SignImm=32'hD5E6F000.
- Invalid op: the J-type DataIn with Op=01100 -> SignImm=32'h0, ImmValid=0, no X on any bit.
- Enable/hold: load the S-type case, then drop en and apply the B-type inputs for 3 edges -> outputs stay 32'hFFFFFF3B / 1. Raise en -> 32'h000008BE after one edge.
